priv_trap_ctrl: RTL

Trap-entry/return controller inside the privilege block, directly downstream of the hazard unit's exception outputs. It prioritises synchronous exceptions and enabled interrupts, latches cause/epc/tval, and raises intr to make the hazard unit drain the pipeline. Once pipe_clear is seen, it redirects fetch through insert_pc/priv_pc and emits a one-cycle CSR-update strobe. It also handles mret redirect to mepc.

---
 rtl/priv_trap_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/priv_trap_ctrl.sv
// Trap-entry / mret controller: prioritises exceptions and interrupts, latches mcause/mepc/mtval,
// holds intr while the pipeline drains, then redirects fetch for exactly one cycle.
module priv_trap_ctrl #(
  parameter int WORD_W = 32,
  parameter bit VEC_EN = 1'b1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              mal_insn,
  input  logic              fault_insn,
  input  logic              illegal_insn,
  input  logic              breakpoint,
  input  logic              env,
  input  logic              mal_l,
  input  logic              fault_l,
  input  logic              mal_s,
  input  logic              fault_s,
  input  logic              fault_insn_page,
  input  logic              fault_load_page,
  input  logic              fault_store_page,
  input  logic              mret,
  input  logic              pipe_clear,
  input  logic [WORD_W-1:0] epc,
  input  logic [WORD_W-1:0] badaddr,
  input  logic              timer_int,
  input  logic              soft_int,
  input  logic              ext_int,
  input  logic              mie_global,
  input  logic [WORD_W-1:0] mtvec,
  input  logic [WORD_W-1:0] mepc_r,
  output logic              intr,
  output logic              insert_pc,
  output logic [WORD_W-1:0] priv_pc,
  output logic              trap_we,
  output logic [WORD_W-1:0] trap_cause,
  output logic [WORD_W-1:0] trap_epc,
  output logic [WORD_W-1:0] trap_tval,
  output logic              mret_we
);

  typedef enum logic [1:0] {IDLE, DRAIN, REDIRECT} state_t;

  state_t            state;
  logic              is_int;
  logic              is_ret;
  logic [3:0]        code;

  logic              exc_valid;
  logic [3:0]        exc_code;
  logic [WORD_W-1:0] exc_tval;
  logic              int_valid;
  logic [3:0]        int_code;

  // Exception priority encoder; mtval is badaddr for address faults, epc for breakpoint.
  always_comb begin
    exc_valid = 1'b1;
    exc_code  = 4'd0;
    exc_tval  = badaddr;
    if (fault_insn_page)       exc_code = 4'd12;
    else if (fault_insn)       exc_code = 4'd1;
    else if (illegal_insn) begin
      exc_code = 4'd2;
      exc_tval = '0;
    end
    else if (mal_insn)         exc_code = 4'd0;
    else if (env) begin
      exc_code = 4'd11;
      exc_tval = '0;
    end
    else if (breakpoint) begin
      exc_code = 4'd3;
      exc_tval = epc;
    end
    else if (mal_s)            exc_code = 4'd6;
    else if (mal_l)            exc_code = 4'd4;
    else if (fault_store_page) exc_code = 4'd15;
    else if (fault_load_page)  exc_code = 4'd13;
    else if (fault_s)          exc_code = 4'd7;
    else if (fault_l)          exc_code = 4'd5;
    else                       exc_valid = 1'b0;
  end

  always_comb begin
    int_valid = mie_global & (ext_int | soft_int | timer_int);
    int_code  = 4'd7;
    if (ext_int)       int_code = 4'd11;
    else if (soft_int) int_code = 4'd3;
  end

  logic [WORD_W-1:0] vec_base;
  logic [WORD_W-1:0] vec_off;
  logic              use_vec;

  assign vec_base = {mtvec[WORD_W-1:2], 2'b00};
  assign vec_off  = {{(WORD_W-6){1'b0}}, code, 2'b00};
  // Reserved modes 2 and 3 fall through to direct mode.
  assign use_vec  = VEC_EN && (mtvec[1:0] == 2'b01) && is_int;

  always_comb begin
    priv_pc = '0;
    if (insert_pc) begin
      if (is_ret)       priv_pc = {mepc_r[WORD_W-1:2], 2'b00};
      else if (use_vec) priv_pc = vec_base + vec_off;
      else              priv_pc = vec_base;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      is_int     <= 1'b0;
      is_ret     <= 1'b0;
      code       <= 4'd0;
      intr       <= 1'b0;
      insert_pc  <= 1'b0;
      trap_we    <= 1'b0;
      mret_we    <= 1'b0;
      trap_cause <= '0;
      trap_epc   <= '0;
      trap_tval  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (exc_valid) begin
            state      <= DRAIN;
            intr       <= 1'b1;
            is_int     <= 1'b0;
            is_ret     <= 1'b0;
            code       <= exc_code;
            trap_cause <= {{(WORD_W-4){1'b0}}, exc_code};
            trap_epc   <= epc;
            trap_tval  <= exc_tval;
          end else if (int_valid) begin
            state      <= DRAIN;
            intr       <= 1'b1;
            is_int     <= 1'b1;
            is_ret     <= 1'b0;
            code       <= int_code;
            trap_cause <= {1'b1, {(WORD_W-5){1'b0}}, int_code};
            trap_epc   <= epc;
            trap_tval  <= '0;
          end else if (mret) begin
            state      <= DRAIN;
            intr       <= 1'b1;
            is_int     <= 1'b0;
            is_ret     <= 1'b1;
            code       <= 4'd0;
            trap_cause <= '0;
            trap_epc   <= '0;
            trap_tval  <= '0;
          end
        end
        DRAIN: begin
          if (pipe_clear) begin
            state     <= REDIRECT;
            insert_pc <= 1'b1;
            trap_we   <= ~is_ret;
            mret_we   <= is_ret;
          end
        end
        REDIRECT: begin
          state     <= IDLE;
          intr      <= 1'b0;
          insert_pc <= 1'b0;
          trap_we   <= 1'b0;
          mret_we   <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          intr      <= 1'b0;
          insert_pc <= 1'b0;
          trap_we   <= 1'b0;
          mret_we   <= 1'b0;
        end
      endcase
    end
  end

endmodule
